// File: rtl/udma_event_collector.sv
// Event pulse collector: per-source pending flags, round-robin arbitration into a small
// ID FIFO whose head drives the uDMA valid/ready event stream. Drops are flagged and counted.
module udma_event_collector #(
    parameter int unsigned N_SRC      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] src_event_i,
    output logic             event_valid_o,
    output logic [7:0]       event_data_o,
    input  logic             event_ready_i,
    output logic [N_SRC-1:0] pending_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o,
    input  logic             clr_i
);

    localparam int unsigned SRC_W = $clog2(N_SRC);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);
    localparam logic [AW:0]      FIFO_FULL = FIFO_DEPTH[AW:0];

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             found;
    logic [SRC_W-1:0] sel;
    int unsigned      idx;
    logic             pop, push_ok, grant_valid;
    logic [N_SRC-1:0] grant_vec, drop_vec;
    logic [8:0]       drop_num;
    logic [9:0]       cnt_sum;

    assign count         = wr_ptr_q - rd_ptr_q;
    assign event_valid_o = (count != '0);
    assign event_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop           = event_valid_o & event_ready_i;
    assign push_ok       = (count != FIFO_FULL) | pop;
    assign grant_valid   = found & push_ok;

    // Search for the first pending source starting at rr_ptr, wrapping at N_SRC-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && pending_q[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant_valid) begin
            grant_vec[sel] = 1'b1;
            rr_ptr_d       = (sel == LAST_SRC) ? '0 : sel + 1'b1;
        end
        pending_d = src_event_i | (pending_q & ~grant_vec);
        drop_vec  = src_event_i & pending_q & ~grant_vec;
    end

    // A clear coincident with drops restarts counting from this cycle's drops.
    always_comb begin
        drop_num = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            drop_num = drop_num + 9'(drop_vec[k]);
        end
        cnt_sum    = (clr_i ? 10'd0 : 10'(drop_cnt_q)) + 10'(drop_num);
        drop_cnt_d = (cnt_sum > 10'd255) ? 8'hFF : cnt_sum[7:0];
        overflow_d = (overflow_q & ~clr_i) | (|drop_vec);
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (grant_valid) begin
                mem_q[wr_ptr_q[AW-1:0]] <= 8'(sel);
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_udma_event_collector.sv
// Self-checking bench for udma_event_collector: directed vector table, corner-case sequences
// and randomized traffic compared against a queue-based reference model.
module tb_udma_event_collector;

    localparam int N = 32;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src_event = '0;
    logic        event_valid;
    logic [7:0]  event_data;
    logic        event_ready = 1'b0;
    logic [31:0] pending;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    udma_event_collector #(
        .N_SRC     (N),
        .FIFO_DEPTH(D)
    ) dut (
        .sys_clk_i    (clk),
        .rst_i        (rst),
        .src_event_i  (src_event),
        .event_valid_o(event_valid),
        .event_data_o (event_data),
        .event_ready_i(event_ready),
        .pending_o    (pending),
        .overflow_o   (overflow),
        .drop_cnt_o   (drop_cnt),
        .clr_i        (clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [31:0] m_pend;
    int        m_ptr;
    int        m_q[$];
    bit        m_ovf;
    int        m_cnt;

    typedef struct {
        bit          do_rst;
        logic [31:0] src;
        bit          rdy;
        bit          clr;
        bit          ev;
        logic [7:0]  ed;
        logic [31:0] ep;
        bit          eo;
        logic [7:0]  ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, logic [31:0] s, bit rd, bit c, bit ev, logic [7:0] ed,
                                logic [31:0] ep, bit eo, logic [7:0] ec);
        vec_t v;
        v = '{r, s, rd, c, ev, ed, ep, eo, ec};
        tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        m_pend = '0;
        m_ptr  = 0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_cnt  = 0;
    endfunction

    function automatic void model_step(logic [31:0] s, bit rdy, bit c);
        int g, drops, idx;
        bit do_pop, ok;
        do_pop = (m_q.size() != 0) && rdy;
        ok     = (m_q.size() < D) || do_pop;
        g      = -1;
        if (ok) begin
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (m_pend[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        drops = 0;
        for (int k = 0; k < N; k++) begin
            if (s[k] && m_pend[k] && k != g) drops++;
        end
        if (g >= 0) m_pend[g] = 1'b0;
        m_pend = m_pend | s;
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g);
            m_ptr = (g + 1) % N;
        end
        if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (drops > 0) m_ovf = 1'b1;
        m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    endfunction

    task automatic cmp(string name, bit ev, logic [7:0] ed, logic [31:0] ep, bit eo,
                       logic [7:0] ec);
        n_vec++;
        if (event_valid !== ev || (ev && event_data !== ed) || pending !== ep ||
            overflow !== eo || drop_cnt !== ec) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%0b d=%02h p=%08h o=%0b c=%0d, want v=%0b d=%02h p=%08h o=%0b c=%0d",
                     name, $time, event_valid, event_data, pending, overflow, drop_cnt,
                     ev, ed, ep, eo, ec);
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, got, exp);
        end
    endtask

    task automatic cmp_model(string name);
        cmp(name, m_q.size() != 0, (m_q.size() != 0) ? 8'(m_q[0]) : 8'h00, m_pend, m_ovf,
            8'(m_cnt));
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs settled.
    task automatic step(logic [31:0] s, bit rdy, bit c);
        src_event   = s;
        event_ready = rdy;
        clr         = c;
        @(posedge clk);
        model_step(s, rdy, c);
        #1;
        cmp_model("model");
    endtask

    task automatic do_reset();
        src_event   = '0;
        event_ready = 1'b0;
        clr         = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cmp("reset", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        check_val("reset_data", 32'(event_data), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        // Single event, latency 2
        add(1, 32'h20, 1, 0, 0, 8'h00, 32'h20, 0, 0);
        add(0, 32'h00, 1, 0, 1, 8'h05, 32'h00, 0, 0);
        add(0, 32'h00, 1, 0, 0, 8'h00, 32'h00, 0, 0);
        // Round-robin order and wrap
        add(1, 32'h00100088, 1, 0, 0, 8'h00, 32'h00100088, 0, 0);
        add(0, 32'h0, 1, 0, 1, 8'h03, 32'h00100080, 0, 0);
        add(0, 32'h0, 1, 0, 1, 8'h07, 32'h00100000, 0, 0);
        add(0, 32'h0, 1, 0, 1, 8'h14, 32'h0, 0, 0);
        add(0, 32'h02000004, 1, 0, 0, 8'h00, 32'h02000004, 0, 0);
        add(0, 32'h0, 1, 0, 1, 8'h19, 32'h4, 0, 0);
        add(0, 32'h0, 1, 0, 1, 8'h02, 32'h0, 0, 0);
        add(0, 32'h0, 1, 0, 0, 8'h00, 32'h0, 0, 0);
        // Back-pressure, full FIFO, drop, drain in order
        add(1, 32'h3F, 0, 0, 0, 8'h00, 32'h3F, 0, 0);
        add(0, 32'h00, 0, 0, 1, 8'h00, 32'h3E, 0, 0);
        add(0, 32'h00, 0, 0, 1, 8'h00, 32'h3C, 0, 0);
        add(0, 32'h00, 0, 0, 1, 8'h00, 32'h38, 0, 0);
        add(0, 32'h00, 0, 0, 1, 8'h00, 32'h30, 0, 0);
        add(0, 32'h00, 0, 0, 1, 8'h00, 32'h30, 0, 0);
        add(0, 32'h10, 0, 0, 1, 8'h00, 32'h30, 1, 1);
        add(0, 32'h00, 1, 0, 1, 8'h01, 32'h20, 1, 1);
        add(0, 32'h00, 1, 0, 1, 8'h02, 32'h00, 1, 1);
        add(0, 32'h00, 1, 0, 1, 8'h03, 32'h00, 1, 1);
        add(0, 32'h00, 1, 0, 1, 8'h04, 32'h00, 1, 1);
        add(0, 32'h00, 1, 0, 1, 8'h05, 32'h00, 1, 1);
        add(0, 32'h00, 1, 0, 0, 8'h00, 32'h00, 1, 1);
        // Pulse in the grant cycle: two events, no drop
        add(1, 32'h200, 1, 0, 0, 8'h00, 32'h200, 0, 0);
        add(0, 32'h200, 1, 0, 1, 8'h09, 32'h200, 0, 0);
        add(0, 32'h000, 1, 0, 1, 8'h09, 32'h000, 0, 0);
        add(0, 32'h000, 1, 0, 0, 8'h00, 32'h000, 0, 0);

        model_reset();
        do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) do_reset();
            step(tbl[i].src, tbl[i].rdy, tbl[i].clr);
            cmp($sformatf("table[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].ep, tbl[i].eo,
                tbl[i].ec);
        end

        // Drop counter saturation and clear
        do_reset();
        for (int i = 0; i < 15; i++) step(32'hFFFF_FFFF, 1'b0, 1'b0);
        check_val("drop_saturate", 32'(drop_cnt), 32'd255);
        check_val("overflow_set", 32'(overflow), 32'd1);
        step(32'h0, 1'b0, 1'b1);
        check_val("clr_cnt", 32'(drop_cnt), 32'd0);
        check_val("clr_ovf", 32'(overflow), 32'd0);
        step(32'h8000_0000, 1'b0, 1'b1);
        check_val("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        check_val("clr_drop_ovf", 32'(overflow), 32'd1);

        // Asynchronous reset with queued and pending events
        do_reset();
        step(32'h1F, 1'b0, 1'b0);
        step(32'h10, 1'b0, 1'b0);
        step(32'h00, 1'b0, 1'b0);
        step(32'h00, 1'b0, 1'b0);
        cmp("pre_async", 1'b1, 8'h00, 32'h18, 1'b1, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst", 1'b0, 8'h00, 32'h0, 1'b0, 8'h00);
        check_val("async_rst_data", 32'(event_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step(32'h0, 1'b1, 1'b0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom & $urandom & $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/udma_event_collector.md
Name: udma_event_collector

Overview:
- Collects single-cycle event pulses from SoC sources (peripheral events, timers, GPIO) and serialises them into the 8-bit valid/ready event stream consumed by the uDMA subsystem (event_valid_i / event_data_i / event_ready_o).
- Each source gets one pending flag. A round-robin arbiter picks one pending source per cycle and pushes its ID into a small FIFO; the FIFO head drives the stream.
- Events lost to back-pressure are flagged and counted.

Parameters:
- N_SRC, 32, number of event sources; legal range 2..256.
- FIFO_DEPTH, 4, event ID FIFO entries; power of two, at least 2.
- SRC_W, $clog2(N_SRC), width of the arbiter pointer (derived, not overridable).

Ports:
- sys_clk_i  in  1  single clock for the whole block.
- rst_i  in  1  reset, asynchronous, active-high.
- src_event_i  in  N_SRC  event pulses; bit k high in a cycle = one event from source k.
- event_valid_o  out  1  FIFO head valid.
- event_data_o  out  8  source ID at FIFO head, zero-extended.
- event_ready_i  in  1  consumer accepts the head this cycle.
- pending_o  out  N_SRC  registered pending flags (debug/status).
- overflow_o  out  1  sticky; set when any event is dropped.
- drop_cnt_o  out  8  saturating count of dropped events.
- clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.

Behaviour:
- Reset (async assert, sync-safe deassert by the integrator) sets:
  - pending_q = 0, FIFO empty, rr_ptr = 0.
  - event_valid_o = 0, event_data_o = 0, pending_o = 0, overflow_o = 0, drop_cnt_o = 0.
- Reset mid-operation discards all pending and queued events; no partial handshake survives.
- Pending update per source k, each cycle:
  - set if src_event_i[k].
  - else clear if granted this cycle.
  - else hold.
- Granted and new pulse in the same cycle: pending stays 1, no drop.
- Drop: src_event_i[k]=1 while pending_q[k]=1 and k is not granted this cycle. Pending stays 1. The drop counts once per dropped source per cycle.
- Multiple drops in one cycle add their count to drop_cnt_o. drop_cnt_o saturates at 255.
- overflow_o is set by any drop and stays set until clr_i.
- clr_i and a drop in the same cycle: the drop wins, so overflow_o=1 and drop_cnt_o = drops that cycle.
- Arbiter (combinational on pending_q):
  - Picks the first pending index searching from rr_ptr upward and wrapping at N_SRC-1 to 0.
  - Grant is issued only if push_ok.
  - On grant: rr_ptr <= granted index + 1, wrapping to 0 after N_SRC-1.
  - No grant: rr_ptr holds.
- push_ok = (count < FIFO_DEPTH) OR (event_valid_o AND event_ready_i). A simultaneous push and pop while full is legal.
- FIFO:
  - Registered read/write pointers with one extra wrap bit.
  - event_valid_o = (count != 0); event_data_o = entry at the read pointer.
  - Pop on event_valid_o AND event_ready_i.
  - event_data_o is stable while valid is high and not accepted (AXI-style: valid never drops without a handshake).
- Latency: pulse in cycle 0 -> pending_q in cycle 1 -> pushed at the end of cycle 1 -> event_valid_o high in cycle 2 (2 cycles minimum).
- Throughput: 1 event/cycle when event_ready_i is held high.
- FIFO full with no pop: no grant, pending flags hold, and further pulses on already-pending sources are dropped per the rules above.
- event_ready_i while FIFO is empty: ignored.

Test Plan:
- Reset, then pulse src 5 in cycle 0 with ready=1 -> event_valid_o=1, event_data_o=0x05 in cycle 2; accepted; pending_o=0 afterwards.
- Pulse srcs 3, 7, 20 in the same cycle, ready=1 -> outputs 0x03, 0x07, 0x14 on consecutive cycles; rr_ptr ends at 21. Then pulse 2 and 25 -> order is 0x19 then 0x02 (wrap).
- Hold ready=0, pulse srcs 0..5 once each -> FIFO holds 0x00..0x03, pending_o=0x30, overflow_o=0. Pulse src 4 again -> drop_cnt_o=1, overflow_o=1. Release ready -> 0x00..0x05 delivered in order.
- Pulse src 9 in exactly the cycle it is granted -> two 0x09 events delivered, drop_cnt_o unchanged.
- Force 300 drops, then clr_i -> drop_cnt_o saturates at 255 and reads 0 after clear; clr_i coincident with one drop -> drop_cnt_o=1, overflow_o=1.
- Assert rst_i asynchronously with FIFO at 3 entries and pending set -> all outputs 0 immediately; no event appears after deassert.
